// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner: drives one column low at a time, samples the rows,
// debounces the whole key map frame by frame and queues one code per clean
// single-key press in a small FIFO read through a valid/ready port.
//
// Handshake: key_valid is high whenever the FIFO holds an entry and key_code
// is the head. An entry is consumed on a clock edge where key_valid and
// key_ready are both high. key_ready is ignored while key_valid is low. The
// producer side (event push) never waits.
module keypad_scan_debounce #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4,
  localparam int CODE_W        = $clog2(ROWS*COLS)
) (
  input  logic                 clk,
  input  logic                 rst,        // asynchronous, active low
  input  logic [ROWS-1:0]      row_in,
  output logic [COLS-1:0]      col_out,
  output logic                 key_valid,
  output logic [CODE_W-1:0]    key_code,
  input  logic                 key_ready,
  output logic [ROWS*COLS-1:0] key_map,
  output logic                 multi_key,
  output logic                 overflow,
  output logic                 dbg_state   // scan FSM state (0 idle, 1 scan)
);

  localparam int NK     = ROWS*COLS;
  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int COL_W  = $clog2(COLS);
  localparam int STAB_W = $clog2(DEBOUNCE_SCANS);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = AW + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_SCANS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [ROWS-1:0]     rows_s1_q, rows_s_q;
  logic [NK-1:0]       raw_q, raw_d;
  logic [NK-1:0]       prev_raw_q, prev_raw_d;
  logic [STAB_W-1:0]   stab_q, stab_d;
  logic                accept_q, accept_d;
  logic [NK-1:0]       key_map_q, key_map_d;
  logic                capture, frame_end;

  logic [CODE_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CODE_W-1:0]   key_code_q, key_code_d;
  logic                overflow_q, overflow_d;
  logic [NK-1:0]       new_bits;
  logic [CODE_W-1:0]   evt_code;
  logic                push_req, push, pop, full;

  // Two-stage synchroniser for the asynchronous row pins (reset to idle level).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rows_s1_q <= '1;
      rows_s_q  <= '1;
    end else begin
      rows_s1_q <= row_in;
      rows_s_q  <= rows_s1_q;
    end
  end

  // Scan FSM state and column/divider counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      div_q   <= div_d;
    end
  end

  // Scan FSM next state: hold each column for SCAN_DIV cycles, capture on the last.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    div_d   = div_q;
    col_out = '1;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_SCAN;
        col_d   = '0;
        div_d   = '0;
      end
      S_SCAN: begin
        col_out = ~(COLS'(1) << col_q);
        if (div_q == DIV_LAST) begin
          capture = 1'b1;
          div_d   = '0;
          col_d   = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign frame_end = capture && (col_q == COL_LAST);
  assign dbg_state = state_q;

  // Raw map update and frame-level stability counting.
  always_comb begin
    raw_d      = raw_q;
    prev_raw_d = prev_raw_q;
    stab_d     = stab_q;
    accept_d   = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (capture && (COL_W'(c) == col_q)) raw_d[r*COLS+c] = ~rows_s_q[r];
      end
    end
    if (frame_end) begin
      if (raw_d == prev_raw_q) stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + STAB_W'(1);
      else                     stab_d = '0;
      prev_raw_d = raw_d;
      accept_d   = (stab_d == STAB_MAX);
    end
  end

  // Debounce registers; accept_q marks the cycle after a stable frame end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_q      <= '0;
      prev_raw_q <= '0;
      stab_q     <= '0;
      accept_q   <= 1'b0;
      key_map_q  <= '0;
    end else begin
      raw_q      <= raw_d;
      prev_raw_q <= prev_raw_d;
      stab_q     <= stab_d;
      accept_q   <= accept_d;
      key_map_q  <= key_map_d;
    end
  end

  // Event decode: a push needs exactly one newly pressed key and one key total.
  always_comb begin
    new_bits  = raw_q & ~key_map_q;
    key_map_d = accept_q ? raw_q : key_map_q;
    push_req  = accept_q && $onehot(new_bits) && $onehot(raw_q);
    evt_code  = '0;
    for (int i = 0; i < NK; i++) begin
      if (new_bits[i]) evt_code = CODE_W'(i);
    end
  end

  // FIFO control: pop first, so a push into a full FIFO survives a same-cycle pop.
  always_comb begin
    pop        = (count_q != '0) && key_ready;
    full       = (count_q == DEPTH_C);
    push       = push_req && (!full || pop);
    overflow_d = overflow_q | (push_req && full && !pop);
    rd_nxt     = rd_ptr_q + AW'(1);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_nxt : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    // key_code is a registered copy of the head that holds once the FIFO drains.
    key_code_d = key_code_q;
    if (pop) begin
      if (count_q > CNT_W'(1)) key_code_d = mem_q[rd_nxt];
      else if (push)           key_code_d = evt_code;
    end else if (push && (count_q == '0)) begin
      key_code_d = evt_code;
    end
  end

  // FIFO pointers, occupancy, head copy and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      key_code_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      key_code_q <= key_code_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are only visible through key_code_q, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= evt_code;
  end

  assign key_valid = (count_q != '0);
  assign key_code  = key_code_q;
  assign key_map   = key_map_q;
  assign multi_key = !$onehot0(key_map_q);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a keypad model closes switches per frame,
// a frame-level reference model predicts key_map and the event queue.
module tb_keypad_scan_debounce;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int NK   = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [ROWS-1:0] row_in;
  logic [COLS-1:0] col_out;
  logic            key_valid;
  logic [3:0]      key_code;
  logic            key_ready = 1'b0;
  logic [NK-1:0]   key_map;
  logic            multi_key;
  logic            overflow;
  logic            dbg_state;

  keypad_scan_debounce #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE_SCANS(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .key_map(key_map), .multi_key(multi_key), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  // Physical keypad: a closed switch pulls its row low while its column is driven low.
  logic [NK-1:0] pressed = '0;
  always_comb begin
    row_in = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r*COLS+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // Scoreboard and reference model state
  logic [3:0]    exp_q[$];
  logic [NK-1:0] hist[$];
  logic [NK-1:0] exp_map;
  logic [3:0]    exp_code;
  logic          exp_ovf;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    hist.delete();
    hist.push_back('0);   // cleared "previous frame" after reset
    exp_map  = '0;
    exp_code = '0;
    exp_ovf  = 1'b0;
  endtask

  // A map is accepted once three consecutive frames show it.
  task automatic model_frame(input logic [NK-1:0] m);
    logic [NK-1:0] nb;
    logic [3:0]    code;
    hist.push_back(m);
    if (hist.size() > 3) void'(hist.pop_front());
    if (hist.size() == 3 && hist[0] == m && hist[1] == m) begin
      nb   = m & ~exp_map;
      code = '0;
      for (int i = 0; i < NK; i++) if (nb[i]) code = 4'(i);
      if ($countones(nb) == 1 && $countones(m) == 1) begin
        if (exp_q.size() == 4) exp_ovf = 1'b1;
        else begin
          if (exp_q.size() == 0) exp_code = code;
          exp_q.push_back(code);
        end
      end
      exp_map = m;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".key_map"},   32'(key_map),   32'(exp_map));
    check_eq({tag, ".multi_key"}, 32'(multi_key), 32'($countones(exp_map) > 1));
    check_eq({tag, ".key_valid"}, 32'(key_valid), 32'(exp_q.size() != 0));
    check_eq({tag, ".key_code"},  32'(key_code),  32'(exp_code));
    check_eq({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".col_out"},   32'(col_out),   32'hF);
    check_eq({tag, ".key_valid"}, 32'(key_valid), 32'h0);
    check_eq({tag, ".key_code"},  32'(key_code),  32'h0);
    check_eq({tag, ".key_map"},   32'(key_map),   32'h0);
    check_eq({tag, ".multi_key"}, 32'(multi_key), 32'h0);
    check_eq({tag, ".overflow"},  32'(overflow),  32'h0);
    check_eq({tag, ".state"},     32'(dbg_state), 32'h0);
  endtask

  // Driver: asynchronous reset assertion, checked immediately.
  task automatic apply_reset(input string tag);
    #2 rst = 1'b0;
    #1 check_reset_values(tag);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Wait (bounded) for the first cycle of column 0.
  task automatic wait_frame_start();
    logic [3:0] last;
    bit found;
    found = 1'b0;
    last  = col_out;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (col_out == 4'hE && last != 4'hE) found = 1'b1;
      last = col_out;
    end
    check_eq("frame_sync", 32'(found), 32'h1);
  endtask

  // Pop every queued entry, checking order, then check key_ready is ignored when empty.
  task automatic drain();
    while (exp_q.size() > 0) begin
      check_eq("pop.valid", 32'(key_valid), 32'h1);
      check_eq("pop.code",  32'(key_code),  32'(exp_q[0]));
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      void'(exp_q.pop_front());
      if (exp_q.size() > 0) exp_code = exp_q[0];
    end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check_eq("empty.valid", 32'(key_valid), 32'h0);
    check_eq("empty.code",  32'(key_code),  32'(exp_code));
  endtask

  // One scan frame with map m closed; outputs reflect frames before this one.
  task automatic run_frame(input logic [NK-1:0] m, input bit do_drain);
    wait_frame_start();
    pressed = m;
    @(negedge clk);
    @(negedge clk);
    check_outputs("frame");
    if (do_drain) drain();
    model_frame(m);
  endtask

  task automatic press(input int k, input int frames, input int release_frames);
    for (int i = 0; i < frames; i++) run_frame(NK'(1) << k, 1'b0);
    for (int i = 0; i < release_frames; i++) run_frame('0, 1'b0);
  endtask

  initial begin
    logic [NK-1:0] m;
    int hold, k1, k2;
    row_in = '1;
    model_reset();

    // 1: reset, then idle column walk E,D,B,7 with 4 clocks each
    apply_reset("reset0");
    wait_frame_start();
    for (int i = 0; i < 16; i++) begin
      check_eq("col_walk", 32'(col_out), 32'(~(4'(1) << (i / 4)) & 4'hF));
      check_eq("idle.valid", 32'(key_valid), 32'h0);
      @(negedge clk);
    end
    model_frame('0);

    // 2: key 6 held for 5 frames -> one event
    press(6, 5, 4);
    drain();

    // 3: bounce on key 6: 1 frame, gap, then 3 stable frames
    press(6, 1, 1);
    press(6, 3, 4);
    drain();

    // 4: keys 0 and 5 together -> map 0x21, multi_key, no event
    for (int i = 0; i < 5; i++) run_frame(16'h0021, 1'b0);
    for (int i = 0; i < 4; i++) run_frame('0, 1'b0);
    drain();

    // 5: five presses without popping -> four queued, fifth dropped
    press(1, 3, 3);
    press(14, 3, 3);
    press(7, 3, 3);
    press(0, 3, 3);
    press(15, 3, 4);
    drain();

    // 6: reset mid-FIFO and mid-debounce; held key re-debounces from scratch
    press(3, 3, 3);
    press(9, 3, 3);
    run_frame(NK'(1) << 11, 1'b0);
    run_frame(NK'(1) << 11, 1'b0);
    apply_reset("reset_mid");
    for (int i = 0; i < 4; i++) run_frame(NK'(1) << 11, 1'b0);
    for (int i = 0; i < 4; i++) run_frame('0, 1'b0);
    drain();

    // Randomised maps and hold lengths with occasional pops
    for (int t = 0; t < 30; t++) begin
      k1 = $urandom_range(0, NK - 1);
      k2 = $urandom_range(0, NK - 1);
      case ($urandom_range(0, 3))
        0:       m = '0;
        3:       m = (NK'(1) << k1) | (NK'(1) << k2);
        default: m = NK'(1) << k1;
      endcase
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) run_frame(m, $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 4; i++) run_frame('0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
